// File: rtl/gpu_def.sv
// Shared encodings for the scheduler dispatch block: fence kinds, message types,
// header field layout and the dispatcher FSM state type.
package gpu_def;

    localparam logic [1:0] FENCE_NONE = 2'd0;
    localparam logic [1:0] FENCE_ACQ  = 2'd1;
    localparam logic [1:0] FENCE_REL  = 2'd2;

    localparam logic [2:0] MSG_NONE   = 3'd0;
    localparam logic [2:0] MSG_MASK   = 3'd1;
    localparam logic [2:0] MSG_R0VEC  = 3'd2;
    localparam logic [2:0] MSG_R0DATA = 3'd3;
    localparam logic [2:0] MSG_INSTR  = 3'd4;

    localparam logic [7:0]  HDR_IFNUM_MASK  = 8'h3F;
    localparam int unsigned HDR_IFNUM_SHIFT = 0;
    localparam logic [7:0]  HDR_FENCE_MASK  = 8'hC0;
    localparam int unsigned HDR_FENCE_SHIFT = 6;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWaitFence,
        StSendMask,
        StSendR0v,
        StSendR0d,
        StSendInstr,
        StDone
    } state_t;

    function automatic logic [5:0] hdr_if_num(input logic [7:0] hdr);
        return 6'((hdr & HDR_IFNUM_MASK) >> HDR_IFNUM_SHIFT);
    endfunction

    function automatic logic [1:0] hdr_fence(input logic [7:0] hdr);
        return 2'((hdr & HDR_FENCE_MASK) >> HDR_FENCE_SHIFT);
    endfunction

endpackage

// File: rtl/sched_prog_mem.sv
// Program store for the dispatcher: register array with a synchronous write port
// and a combinational read port.
module sched_prog_mem #(
    parameter int unsigned MSG_W     = 16,
    parameter int unsigned MEM_DEPTH = 1024,
    localparam int unsigned AW       = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [MSG_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [MSG_W-1:0] rdata
);

    logic [MSG_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sched_dispatch.sv
// Walks a frame-structured program, honours per-task fences against core_busy and
// streams mask / r0 / instruction messages to the cores under a per-core ack handshake.
module sched_dispatch
    import gpu_def::*;
#(
    parameter int unsigned CORE_NUM    = 16,
    parameter int unsigned MSG_W       = 16,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned FRAME_WORDS = 16,
    localparam int unsigned AW         = $clog2(MEM_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                prog_we,
    input  logic [AW-1:0]       prog_addr,
    input  logic [MSG_W-1:0]    prog_data,
    input  logic                start,
    input  logic [CORE_NUM-1:0] core_busy,
    input  logic [CORE_NUM-1:0] core_ack,
    output logic                msg_valid,
    output logic [MSG_W-1:0]    msg_data,
    output logic [2:0]          msg_type,
    output logic [CORE_NUM-1:0] msg_mask,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned FW_LOG   = $clog2(FRAME_WORDS);
    localparam int unsigned CW       = 6 + FW_LOG;
    localparam logic [AW-1:0] PTR_LAST = AW'(MEM_DEPTH - 1);
    localparam logic [CW-1:0] R0D_LAST = CW'(FRAME_WORDS - 4);

    state_t              state_q, state_d, adv_state;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [CORE_NUM-1:0] mask_q, mask_d, last_mask_q, last_mask_d, new_mask;
    logic [5:0]          if_num_q, if_num_d;
    logic [1:0]          fence_q, fence_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_next;
    logic                err_q, err_d;
    logic                accept, fence_ok, is_send, task_end, mem_we;
    logic [MSG_W-1:0]    rd_word;

    assign mem_we = prog_we && !busy;

    sched_prog_mem #(
        .MSG_W     (MSG_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (ptr_q),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            mask_q      <= '0;
            last_mask_q <= '0;
            if_num_q    <= '0;
            fence_q     <= FENCE_NONE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mask_q      <= mask_d;
            last_mask_q <= last_mask_d;
            if_num_q    <= if_num_d;
            fence_q     <= fence_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mask_d      = mask_q;
        last_mask_d = last_mask_q;
        if_num_d    = if_num_q;
        fence_d     = fence_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        adv_state   = state_q;
        cnt_next    = cnt_q;
        is_send     = 1'b0;
        task_end    = 1'b0;
        // In WAIT_FENCE ptr already points at the mask word of the new task.
        new_mask    = CORE_NUM'(rd_word);
        accept      = (core_ack & mask_q) == mask_q;

        fence_ok = (new_mask & core_busy) == '0;
        case (fence_q)
            FENCE_NONE: ;
            FENCE_ACQ:  fence_ok = fence_ok && ((last_mask_q & core_busy) == '0);
            default:    fence_ok = fence_ok && (core_busy == '0);
        endcase

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHdr;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StHdr: begin
                if (rd_word == '0) begin
                    state_d = StDone;
                end else if (ptr_q == PTR_LAST) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    if_num_d = hdr_if_num(rd_word[7:0]);
                    fence_d  = hdr_fence(rd_word[7:0]);
                    ptr_d    = ptr_q + AW'(1);
                    state_d  = StWaitFence;
                end
            end
            StWaitFence: begin
                if (new_mask == '0) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (fence_ok) begin
                    mask_d  = new_mask;
                    state_d = StSendMask;
                end
            end
            StSendMask: begin
                is_send   = 1'b1;
                adv_state = StSendR0v;
            end
            StSendR0v: begin
                is_send   = 1'b1;
                adv_state = StSendR0d;
                cnt_next  = '0;
            end
            StSendR0d: begin
                is_send = 1'b1;
                if (cnt_q != R0D_LAST) begin
                    adv_state = StSendR0d;
                    cnt_next  = cnt_q + CW'(1);
                end else if (if_num_q == '0) begin
                    adv_state = StHdr;
                    task_end  = 1'b1;
                end else begin
                    // Instruction counter runs down from if_num*FRAME_WORDS-1 to zero.
                    adv_state = StSendInstr;
                    cnt_next  = {if_num_q, {FW_LOG{1'b0}}} - CW'(1);
                end
            end
            StSendInstr: begin
                is_send = 1'b1;
                if (cnt_q == '0) begin
                    adv_state = StHdr;
                    task_end  = 1'b1;
                end else begin
                    cnt_next = cnt_q - CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The last memory word can still be sent, but nothing may follow it.
        if (is_send && accept) begin
            if (ptr_q == PTR_LAST) begin
                err_d   = 1'b1;
                state_d = StDone;
            end else begin
                ptr_d   = ptr_q + AW'(1);
                state_d = adv_state;
                cnt_d   = cnt_next;
                if (task_end) begin
                    last_mask_d = mask_q;
                end
            end
        end
    end

    always_comb begin
        msg_type = MSG_NONE;
        unique case (state_q)
            StSendMask:  msg_type = MSG_MASK;
            StSendR0v:   msg_type = MSG_R0VEC;
            StSendR0d:   msg_type = MSG_R0DATA;
            StSendInstr: msg_type = MSG_INSTR;
            default:     msg_type = MSG_NONE;
        endcase
    end

    assign msg_valid = (msg_type != MSG_NONE);
    assign msg_data  = msg_valid ? rd_word : '0;
    assign msg_mask  = mask_q;
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign done      = (state_q == StDone);
    assign err       = err_q;

endmodule
